// File: rtl/camera_reg_patcher.sv
// Round-robin, coalescing patcher of NUM_CH value channels into camera-settings BRAM slots.
// Optional macro CAM_PATCH_AUTOINIT_EN adds an automatic init request after each write burst.
module camera_reg_patcher #(
  parameter int unsigned          NUM_CH      = 4,
  parameter int unsigned          VAL_W       = 16,
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          SLOT_BASE   = 224,
  parameter logic [NUM_CH*16-1:0] CH_REG_ADDR = {16'h3402, 16'h3400, 16'h350A, 16'h3501}
) (
  input  logic                      clk_camera,
  input  logic                      sys_rst_camera,
  input  logic [NUM_CH*VAL_W-1:0]   ch_value,
  input  logic [NUM_CH-1:0]         ch_update,
  input  logic                      bus_active,
  input  logic                      cfg_init_ready,
  output logic                      cfg_init_valid,
  output logic                      bram_sel,
  output logic                      bram_we,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [23:0]               bram_din,
  output logic [NUM_CH-1:0]         pending,
  output logic                      busy
);

  localparam int unsigned BYTES = VAL_W / 8;
  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  if (VAL_W % 8 != 0) begin : g_err_val_w
    $error("camera_reg_patcher: VAL_W must be a multiple of 8");
  end
  if (SLOT_BASE + NUM_CH * BYTES > 2 ** ADDR_W) begin : g_err_slots
    $error("camera_reg_patcher: slot range exceeds BRAM address space");
  end

`ifdef CAM_PATCH_AUTOINIT_EN
  typedef enum logic [1:0] {IDLE, WRITE, INIT_REQ, INIT_WAIT} state_t;
`else
  typedef enum logic [0:0] {IDLE, WRITE} state_t;
  logic unused_init_ready;
  assign unused_init_ready = cfg_init_ready;
  assign cfg_init_valid    = 1'b0;
`endif

  state_t              state, state_n;
  logic [VAL_W-1:0]    shadow [NUM_CH];
  logic [VAL_W-1:0]    snap;
  logic [CW-1:0]       rr_ptr, ch_sel, gnt_ch;
  logic [BW-1:0]       byte_idx;
  logic                gnt_found, grant, last_byte, wr;
  logic [NUM_CH-1:0]   pend_n;
  logic [ADDR_W-1:0]   addr_c;
  logic [23:0]         din_c;
  int unsigned         cand;

  // First pending channel at or after rr_ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_CH;
      if (!gnt_found && pending[cand]) begin
        gnt_found = 1'b1;
        gnt_ch    = CW'(cand);
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    last_byte = (byte_idx == BW'(BYTES - 1));
    case (state)
      IDLE: if (gnt_found && !bus_active) begin
        grant   = 1'b1;
        state_n = WRITE;
      end
      WRITE: if (last_byte) begin
`ifdef CAM_PATCH_AUTOINIT_EN
        state_n = (pending == '0) ? INIT_REQ : IDLE;
`else
        state_n = IDLE;
`endif
      end
`ifdef CAM_PATCH_AUTOINIT_EN
      INIT_REQ:  if (cfg_init_valid && cfg_init_ready) state_n = INIT_WAIT;
      INIT_WAIT: if (!bus_active && cfg_init_ready) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase

    // A strobe coinciding with its own grant re-arms pending so the newest value is rewritten
    pend_n = pending;
    if (grant) pend_n[gnt_ch] = 1'b0;
    pend_n = pend_n | ch_update;

    wr     = (state == WRITE);
    addr_c = ADDR_W'(SLOT_BASE + int'(ch_sel) * BYTES + int'(byte_idx));
    din_c  = {CH_REG_ADDR[16*ch_sel +: 16] + 16'(byte_idx),
              8'(snap >> (VAL_W - 8 - 8 * int'(byte_idx)))};
  end

  always_ff @(posedge clk_camera) begin
    if (sys_rst_camera) begin
      state     <= IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      ch_sel    <= '0;
      byte_idx  <= '0;
      snap      <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) shadow[c] <= '0;
      bram_sel  <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      busy      <= 1'b0;
`ifdef CAM_PATCH_AUTOINIT_EN
      cfg_init_valid <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      pending <= pend_n;
      for (int unsigned c = 0; c < NUM_CH; c++)
        if (ch_update[c]) shadow[c] <= ch_value[VAL_W*c +: VAL_W];
      if (grant) begin
        snap     <= shadow[gnt_ch];
        ch_sel   <= gnt_ch;
        byte_idx <= '0;
        rr_ptr   <= (gnt_ch == CW'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
      end else if (wr) begin
        byte_idx <= byte_idx + 1'b1;
      end
      bram_sel  <= wr;
      bram_we   <= wr;
      bram_addr <= wr ? addr_c : '0;
      bram_din  <= wr ? din_c : '0;
      busy      <= (state != IDLE);
`ifdef CAM_PATCH_AUTOINIT_EN
      cfg_init_valid <= (state_n == INIT_REQ);
`endif
    end
  end

`ifndef SYNTHESIS
  a_no_bus_during_write: assert property (@(posedge clk_camera) disable iff (sys_rst_camera)
    !(state == WRITE && $rose(bus_active)));
`endif

endmodule

// File: tb/tb_camera_reg_patcher.sv
// Randomised and directed checks of camera_reg_patcher against a transaction-level model.
module tb_camera_reg_patcher;
  localparam int NUM_CH = 4, VAL_W = 16, ADDR_W = 8, SLOT_BASE = 224, BYTES = VAL_W / 8;
  localparam logic [63:0] CRA = {16'h3402, 16'h3400, 16'h350A, 16'h3501};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH*VAL_W-1:0] val = '0;
  logic [NUM_CH-1:0] upd = '0;
  logic bus = 1'b0, rdy = 1'b1;
  logic cfg_valid, sel, we, busy;
  logic [ADDR_W-1:0] addr;
  logic [23:0] din;
  logic [NUM_CH-1:0] pend;

  camera_reg_patcher #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .ADDR_W(ADDR_W),
    .SLOT_BASE(SLOT_BASE), .CH_REG_ADDR(CRA)) dut (
    .clk_camera(clk), .sys_rst_camera(rst), .ch_value(val), .ch_update(upd),
    .bus_active(bus), .cfg_init_ready(rdy), .cfg_init_valid(cfg_valid),
    .bram_sel(sel), .bram_we(we), .bram_addr(addr), .bram_din(din),
    .pending(pend), .busy(busy));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of BRAM beats still to appear, plus init phase (0 none, 1 request, 2 wait)
  typedef struct { logic [ADDR_W-1:0] a; logic [23:0] d; } beat_t;
  beat_t plan[$];
  logic [VAL_W-1:0] m_shadow [NUM_CH];
  logic [NUM_CH-1:0] m_pend = '0;
  int m_rr = 0, m_mode = 0;
  logic e_sel = 0, e_we = 0, e_busy = 0, e_valid = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [23:0] e_din = '0;
  logic [NUM_CH-1:0] e_pend = '0;

  task automatic model_step();
    beat_t b;
    int c;
    bit was_busy, last;
    if (rst) begin
      plan.delete();
      m_pend = '0; m_rr = 0; m_mode = 0;
      for (int i = 0; i < NUM_CH; i++) m_shadow[i] = '0;
      {e_sel, e_we, e_busy, e_valid, e_addr, e_din, e_pend} = '0;
      return;
    end
    was_busy = (plan.size() != 0) || (m_mode != 0);
    e_busy = was_busy;
    {e_sel, e_we, e_addr, e_din} = '0;
    last = 0;
    if (plan.size() != 0) begin
      b = plan.pop_front();
      e_sel = 1; e_we = 1; e_addr = b.a; e_din = b.d;
      last = (plan.size() == 0);
    end
`ifdef CAM_PATCH_AUTOINIT_EN
    if (m_mode == 1) begin
      if (e_valid && rdy) m_mode = 2;
    end else if (m_mode == 2) begin
      if (!bus && rdy) m_mode = 0;
    end
    if (last && m_pend == '0) m_mode = 1;
    e_valid = (m_mode == 1);
`else
    e_valid = 0;
`endif
    if (!was_busy && !bus && m_pend != '0) begin
      c = m_rr;
      for (int i = 0; i < NUM_CH; i++) begin
        c = (m_rr + i) % NUM_CH;
        if (m_pend[c]) break;
      end
      for (int k = 0; k < BYTES; k++) begin
        b.a = ADDR_W'(SLOT_BASE + c * BYTES + k);
        b.d = {CRA[16*c +: 16] + 16'(k), 8'(m_shadow[c] >> (VAL_W - 8 - 8 * k))};
        plan.push_back(b);
      end
      m_pend[c] = 1'b0;
      m_rr = (c + 1) % NUM_CH;
    end
    for (int i = 0; i < NUM_CH; i++)
      if (upd[i]) begin
        m_shadow[i] = val[VAL_W*i +: VAL_W];
        m_pend[i] = 1'b1;
      end
    e_pend = m_pend;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("bram_sel", sel, e_sel);
      chk("bram_we", we, e_we);
      chk("bram_addr", addr, e_addr);
      chk("bram_din", din, e_din);
      chk("pending", pend, e_pend);
      chk("busy", busy, e_busy);
      chk("cfg_init_valid", cfg_valid, e_valid);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; upd = '0; bus = 0; rdy = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  int unsigned addrs[$];
  int n;
  logic [7:0] d0, d1;
  bit found;

  initial begin
    // Test 1: single ch0 write, latency and data layout
    do_reset();
    val[15:0] = 16'hA55A; upd = 4'b0001;
    cyc(); upd = '0;
    chk("t1_we_t0", we, 0);
    cyc(); chk("t1_we_t1", we, 0);
    cyc(); chk("t1_beat0", {we, addr, din}, {1'b1, 8'd224, 24'h3501A5});
    cyc(); chk("t1_beat1", {we, addr, din}, {1'b1, 8'd225, 24'h35025A});
    chk("t1_busy_last", busy, 1);
    cyc(); chk("t1_we_after", {sel, we}, 2'b00);
`ifndef CAM_PATCH_AUTOINIT_EN
    chk("t1_busy_drop", busy, 0);
`endif
    repeat (6) cyc();

    // Test 2: coalescing while the bus is busy
    do_reset();
    bus = 1; val[15:0] = 16'h1111; upd = 4'b0001;
    cyc(); val[15:0] = 16'h2222;
    cyc(); upd = '0;
    n = 0;
    repeat (4) begin cyc(); if (we) n++; end
    chk("t2_no_write_bus", n, 0);
    bus = 0; n = 0; d0 = '0; d1 = '0;
    repeat (10) begin
      cyc();
      if (we) begin if (n == 0) d0 = din[7:0]; else d1 = din[7:0]; n++; end
    end
    chk("t2_write_count", n, 2);
    chk("t2_bytes", {d0, d1}, 16'h2222);

    // Test 3: all four channels, then RR after wrap
    do_reset();
    for (int i = 0; i < NUM_CH; i++) val[16*i +: 16] = 16'(16'h1234 * (i + 1));
    upd = 4'hF;
    cyc(); upd = '0;
    addrs.delete();
    repeat (30) begin cyc(); if (we) addrs.push_back(int'(addr)); end
    chk("t3_count", addrs.size(), 8);
    for (int i = 0; i < 8 && i < addrs.size(); i++) chk("t3_order", addrs[i], 224 + i);
    chk("t3_pending", pend, 0);
    upd = 4'b1001;
    cyc(); upd = '0;
    addrs.delete();
    repeat (20) begin cyc(); if (we) addrs.push_back(int'(addr)); end
    chk("t3b_count", addrs.size(), 4);
    if (addrs.size() == 4)
      chk("t3b_order", {8'(addrs[0]), 8'(addrs[1]), 8'(addrs[2]), 8'(addrs[3])},
          {8'd224, 8'd225, 8'd230, 8'd231});

    // Test 4: reset during 2nd byte of a ch2 write
    do_reset();
    val[47:32] = 16'hBEEF; upd = 4'b0100;
    cyc(); upd = '0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (we && addr == 8'd229) found = 1;
    end
    chk("t4_found_byte1", found, 1);
    rst = 1;
    cyc();
    chk("t4_all_zero", {cfg_valid, sel, we, addr, din, pend, busy}, '0);
    rst = 0; n = 0;
    repeat (10) begin cyc(); if (we) n++; end
    chk("t4_no_writes", n, 0);

`ifdef CAM_PATCH_AUTOINIT_EN
    // Test 5: init request held while not ready, then a second write and init
    do_reset();
    rdy = 0; val[31:16] = 16'h0F0F; upd = 4'b0010;
    cyc(); upd = '0;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin cyc(); if (cfg_valid) found = 1; end
    chk("t5_valid_seen", found, 1);
    n = 0;
    repeat (5) begin cyc(); if (cfg_valid) n++; end
    chk("t5_valid_held", n, 5);
    rdy = 1; bus = 1;
    cyc();
    val[31:16] = 16'hF0F0; upd = 4'b0010;
    cyc(); upd = '0;
    repeat (2) cyc();
    bus = 0; n = 0; found = 0;
    repeat (20) begin
      cyc();
      if (we) n++;
      if (cfg_valid && rdy) found = 1;
    end
    chk("t5_second_write", n, 2);
    chk("t5_second_init", found, 1);
`endif

    // Random phase
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        upd[c] = ($urandom_range(0, 5) == 0);
        val[16*c +: 16] = 16'($urandom);
      end
      if (bus) bus = ($urandom_range(0, 3) != 0);
      else if (plan.size() == 0) bus = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
    end
    upd = '0; bus = 0; rdy = 1; rst = 0;
    repeat (30) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
